// File: rtl/mio_bus_responder.sv
// Memory/IO responder for the CPU memory-IO bus: word RAM plus a small peripheral register file.
// Optional timer interrupt (compare register, pending flag, INT line) enabled by defining TIMER_INT_EN.
module mio_bus_responder #(
    parameter int          RAM_WORDS   = 1024,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] IO_BASE     = 32'hFFFF_FF00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        CPU_MIO,
    input  logic        mem_w,
    input  logic [31:0] Addr_out,
    input  logic [31:0] Data_out,
    output logic [31:0] Data_in,
    output logic        MIO_ready,
    output logic        INT,
    input  logic [15:0] sw,
    output logic [15:0] led
);

    localparam int AW = $clog2(RAM_WORDS);
    localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    localparam logic [5:0] OFF_LED   = 6'd0;
    localparam logic [5:0] OFF_SW    = 6'd1;
    localparam logic [5:0] OFF_CYCLE = 6'd2;
    localparam logic [5:0] OFF_CMP   = 6'd3;
    localparam logic [5:0] OFF_ISTAT = 6'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_s;
    logic [3:0]    wait_cnt_r;
    logic [3:0]    wait_cnt_s;

    logic [31:2]   addr_r;
    logic [31:0]   wdata_r;
    logic          wr_r;

    logic [31:2]   req_addr_s;
    logic [31:0]   req_wdata_s;
    logic          req_wr_s;
    logic          commit_s;
    logic          is_io_s;
    logic [5:0]    io_off_s;
    logic [AW-1:0] ram_idx_s;
    logic [31:0]   rdata_s;

    logic          ram_we_s;
    logic          led_we_s;
    logic          cyc_we_s;

    logic [31:0]   ram_r [RAM_WORDS];
    logic [31:0]   data_in_r;
    logic          mio_ready_r;
    logic [15:0]   led_r;
    logic [31:0]   cycle_r;

    logic          unused_bits_s;
    assign unused_bits_s = ^Addr_out[1:0];

    // Next-state logic and wait-state counting
    always_comb begin
        state_s    = state_r;
        wait_cnt_s = wait_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (CPU_MIO) begin
                    wait_cnt_s = 4'd0;
                    if (WAIT_CYCLES > 0) begin
                        state_s = ST_WAIT;
                    end else begin
                        state_s = ST_ACK;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_r == WAIT_LAST) begin
                    state_s    = ST_ACK;
                    wait_cnt_s = 4'd0;
                end else begin
                    wait_cnt_s = wait_cnt_r + 4'd1;
                end
            end
            ST_ACK:  state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // With zero wait states the commit edge is the sampling edge, so the live bus is used in IDLE
    always_comb begin
        if (state_r == ST_IDLE) begin
            req_addr_s  = Addr_out[31:2];
            req_wdata_s = Data_out;
            req_wr_s    = mem_w;
        end else begin
            req_addr_s  = addr_r;
            req_wdata_s = wdata_r;
            req_wr_s    = wr_r;
        end
    end

    assign commit_s  = (state_s == ST_ACK) && (state_r != ST_ACK);
    assign is_io_s   = (req_addr_s[31:8] == IO_BASE[31:8]);
    assign io_off_s  = req_addr_s[7:2];
    assign ram_idx_s = req_addr_s[AW+1:2];

    assign ram_we_s  = commit_s && req_wr_s && !is_io_s;
    assign led_we_s  = commit_s && req_wr_s && is_io_s && (io_off_s == OFF_LED);
    assign cyc_we_s  = commit_s && req_wr_s && is_io_s && (io_off_s == OFF_CYCLE);

`ifdef TIMER_INT_EN
    logic [31:0] cmp_r;
    logic        pending_r;
    logic        cmp_we_s;
    logic        istat_we_s;

    assign cmp_we_s   = commit_s && req_wr_s && is_io_s && (io_off_s == OFF_CMP);
    assign istat_we_s = commit_s && req_wr_s && is_io_s && (io_off_s == OFF_ISTAT);

    // Timer compare register and pending flag; a set on the same edge as a clear wins
    always_ff @(posedge clk) begin
        if (!reset) begin
            cmp_r     <= 32'd0;
            pending_r <= 1'b0;
        end else begin
            if (cmp_we_s) begin
                cmp_r <= req_wdata_s;
            end
            if ((cycle_r == cmp_r) && (cmp_r != 32'd0)) begin
                pending_r <= 1'b1;
            end else if (istat_we_s && req_wdata_s[0]) begin
                pending_r <= 1'b0;
            end
        end
    end

    assign INT = pending_r;
`else
    assign INT = 1'b0;
`endif

    // Read data mux for the current request
    always_comb begin
        rdata_s = 32'd0;
        if (is_io_s) begin
            case (io_off_s)
                OFF_LED:   rdata_s = {16'd0, led_r};
                OFF_SW:    rdata_s = {16'd0, sw};
                OFF_CYCLE: rdata_s = cycle_r;
`ifdef TIMER_INT_EN
                OFF_CMP:   rdata_s = cmp_r;
                OFF_ISTAT: rdata_s = {31'd0, pending_r};
`endif
                default:   rdata_s = 32'd0;
            endcase
        end else begin
            rdata_s = ram_r[ram_idx_s];
        end
    end

    // FSM state register and request latch
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            wait_cnt_r <= 4'd0;
            addr_r     <= 30'd0;
            wdata_r    <= 32'd0;
            wr_r       <= 1'b0;
        end else begin
            state_r    <= state_s;
            wait_cnt_r <= wait_cnt_s;
            if ((state_r == ST_IDLE) && CPU_MIO) begin
                addr_r  <= Addr_out[31:2];
                wdata_r <= Data_out;
                wr_r    <= mem_w;
            end
        end
    end

    // RAM storage; contents survive reset, but a write in flight during reset is dropped
    always_ff @(posedge clk) begin
        if (reset && ram_we_s) begin
            ram_r[ram_idx_s] <= req_wdata_s;
        end
    end

    // Completion strobe and read data, both updated on the edge entering ACK
    always_ff @(posedge clk) begin
        if (!reset) begin
            mio_ready_r <= 1'b0;
            data_in_r   <= 32'd0;
        end else begin
            mio_ready_r <= (state_s == ST_ACK);
            if (commit_s && !req_wr_s) begin
                data_in_r <= rdata_s;
            end
        end
    end

    // LED register and free-running cycle counter (a bus write beats the increment)
    always_ff @(posedge clk) begin
        if (!reset) begin
            led_r   <= 16'd0;
            cycle_r <= 32'd0;
        end else begin
            if (led_we_s) begin
                led_r <= req_wdata_s[15:0];
            end
            if (cyc_we_s) begin
                cycle_r <= req_wdata_s;
            end else begin
                cycle_r <= cycle_r + 32'd1;
            end
        end
    end

    assign Data_in   = data_in_r;
    assign MIO_ready = mio_ready_r;
    assign led       = led_r;

endmodule

// File: tb/tb_mio_bus_responder.sv
// Self-checking bench for mio_bus_responder: directed bus scenarios followed by random traffic
// checked against a transaction-level model (RAM array, LED value, cycle counter anchored to edge numbers).
module tb_mio_bus_responder;

    localparam int          W    = 2;
    localparam logic [31:0] IOB  = 32'hFFFF_FF00;

    logic        clk = 1'b0;
    logic        reset;
    logic        CPU_MIO;
    logic        mem_w;
    logic [31:0] Addr_out;
    logic [31:0] Data_out;
    logic [31:0] Data_in;
    logic        MIO_ready;
    logic        INT;
    logic [15:0] sw;
    logic [15:0] led;

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;

    // Reference model state
    logic [31:0] ram_m [1024];
    bit          written_m [1024];
    logic [15:0] led_m;
    logic [31:0] anc_val;
    int          anc_edge;

    mio_bus_responder #(
        .RAM_WORDS  (1024),
        .WAIT_CYCLES(W),
        .IO_BASE    (IOB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .CPU_MIO  (CPU_MIO),
        .mem_w    (mem_w),
        .Addr_out (Addr_out),
        .Data_out (Data_out),
        .Data_in  (Data_in),
        .MIO_ready(MIO_ready),
        .INT      (INT),
        .sw       (sw),
        .led      (led)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt = edge_cnt + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Counter value seen by the DUT just before edge e
    function automatic logic [31:0] cyc_at(int e);
        return anc_val + 32'(e - anc_edge - 1);
    endfunction

    function automatic bit is_io(logic [31:0] a);
        return a[31:8] == IOB[31:8];
    endfunction

    function automatic logic [31:0] model_read(logic [31:0] a, int ec, output bit known);
        logic [9:0] idx;
        known = 1'b1;
        if (is_io(a)) begin
            case (a[7:2])
                6'd0:    return {16'd0, led_m};
                6'd1:    return {16'd0, sw};
                6'd2:    return cyc_at(ec);
                default: return 32'd0;
            endcase
        end
        idx   = a[11:2];
        known = written_m[idx];
        return ram_m[idx];
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input int ec);
        logic [9:0] idx;
        if (is_io(a)) begin
            if (a[7:2] == 6'd0) led_m = d[15:0];
            if (a[7:2] == 6'd2) begin
                anc_val  = d;
                anc_edge = ec;
            end
        end else begin
            idx = a[11:2];
            ram_m[idx]     = d;
            written_m[idx] = 1'b1;
        end
    endtask

    // Caller is at a negedge with the DUT idle; returns at the negedge of the following IDLE cycle
    task automatic xfer(input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input string tag, output logic [31:0] rdata);
        int  k;
        int  e0;
        int  ec;
        bit  known;
        logic [31:0] exp;
        CPU_MIO  = 1'b1;
        mem_w    = wr;
        Addr_out = a;
        Data_out = d;
        @(posedge clk);
        k  = 0;
        e0 = 0;
        for (int i = 1; i <= W + 6 && k == 0; i++) begin
            @(negedge clk);
            if (i == 1) e0 = edge_cnt;
            if (MIO_ready === 1'b1) begin
                k = i;
            end else begin
                Addr_out = $urandom;
                Data_out = $urandom;
                mem_w    = ~wr;
            end
        end
        check({tag, " latency"}, 32'(k), 32'(W + 1));
        ec      = e0 + W;
        rdata   = Data_in;
        CPU_MIO = 1'b0;
        mem_w   = 1'b0;
        if (!wr) begin
            exp = model_read(a, ec, known);
            if (known) check({tag, " rdata"}, rdata, exp);
        end else begin
            model_write(a, d, ec);
        end
        @(negedge clk);
        check({tag, " pulse width"}, {31'd0, MIO_ready}, 32'd0);
    endtask

    task automatic do_reset(input int n);
        reset   = 1'b0;
        CPU_MIO = 1'b0;
        repeat (n) @(negedge clk);
        anc_val  = 32'd0;
        anc_edge = edge_cnt;
        led_m    = 16'd0;
        check("reset ready", {31'd0, MIO_ready}, 32'd0);
        check("reset data_in", Data_in, 32'd0);
        check("reset led", {16'd0, led}, 32'd0);
        check("reset int", {31'd0, INT}, 32'd0);
        reset = 1'b1;
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] a;
        bit          saw;
        reset    = 1'b0;
        CPU_MIO  = 1'b0;
        mem_w    = 1'b0;
        Addr_out = 32'd0;
        Data_out = 32'd0;
        sw       = 16'd0;
        for (int i = 0; i < 1024; i++) written_m[i] = 1'b0;
        @(negedge clk);
        do_reset(3);

        // Timer interrupt scenario: compare at 100
`ifdef TIMER_INT_EN
        xfer(1'b1, IOB + 32'h0C, 32'd100, "cmp wr", r);
        xfer(1'b0, IOB + 32'h0C, 32'd0, "cmp rd", r);
        check("cmp value", r, 32'd100);
        check("int before match", {31'd0, INT}, 32'd0);
        while (edge_cnt < anc_edge + 110) @(negedge clk);
        check("int after match", {31'd0, INT}, 32'd1);
        repeat (5) @(negedge clk);
        check("int sticky", {31'd0, INT}, 32'd1);
        xfer(1'b0, IOB + 32'h10, 32'd0, "istat rd", r);
        check("istat pending", r, 32'd1);
        xfer(1'b1, IOB + 32'h10, 32'd1, "istat clr", r);
        check("int cleared", {31'd0, INT}, 32'd0);
`else
        xfer(1'b1, IOB + 32'h0C, 32'd100, "cmp wr", r);
        xfer(1'b0, IOB + 32'h0C, 32'd0, "cmp rd", r);
        xfer(1'b1, IOB + 32'h10, 32'd1, "istat wr", r);
        xfer(1'b0, IOB + 32'h10, 32'd0, "istat rd", r);
        while (edge_cnt < anc_edge + 110) @(negedge clk);
        check("int tied low", {31'd0, INT}, 32'd0);
`endif

        xfer(1'b1, 32'h14, 32'hDEAD_BEEF, "wr 0x14", r);
        xfer(1'b0, 32'h14, 32'd0, "rd 0x14", r);
        check("deadbeef", r, 32'hDEAD_BEEF);
        xfer(1'b1, 32'h1000, 32'd5, "wr 0x1000", r);
        xfer(1'b0, 32'h0, 32'd0, "rd 0x0", r);
        check("ram wrap", r, 32'd5);
        xfer(1'b0, 32'h2, 32'd0, "rd 0x2", r);
        check("byte bits ignored", r, 32'd5);

        xfer(1'b1, IOB, 32'h0001_A5A5, "led wr", r);
        check("led out", {16'd0, led}, 32'h0000_A5A5);
        xfer(1'b0, IOB, 32'd0, "led rd", r);
        check("led readback", r, 32'h0000_A5A5);
        sw = 16'h1234;
        xfer(1'b0, IOB + 32'h04, 32'd0, "sw rd", r);
        check("sw value", r, 32'h0000_1234);
        xfer(1'b1, IOB + 32'h40, 32'hFFFF_FFFF, "hole wr", r);
        xfer(1'b0, IOB + 32'h40, 32'd0, "hole rd", r);
        check("hole zero", r, 32'd0);

        xfer(1'b1, IOB + 32'h08, 32'hFFFF_FFFE, "cyc wr", r);
        xfer(1'b0, IOB + 32'h08, 32'd0, "cyc rd1", r1);
        xfer(1'b0, IOB + 32'h08, 32'd0, "cyc rd2", r2);
        check("cyc wrapped", r1, 32'd1);
        check("cyc delta", r2 - r1, 32'd4);

        // Reset during the wait states of a write
        xfer(1'b1, 32'h20, 32'h11, "pre wr 0x20", r);
        xfer(1'b0, 32'h20, 32'd0, "pre rd 0x20", r);
        CPU_MIO  = 1'b1;
        mem_w    = 1'b1;
        Addr_out = 32'h20;
        Data_out = 32'h77;
        @(posedge clk);
        @(negedge clk);
        reset   = 1'b0;
        CPU_MIO = 1'b0;
        saw     = 1'b0;
        repeat (3) begin
            @(negedge clk);
            saw = saw | (MIO_ready === 1'b1);
        end
        check("abort no ready", {31'd0, saw}, 32'd0);
        do_reset(1);
        check("abort ready after", {31'd0, MIO_ready}, 32'd0);
        xfer(1'b0, 32'h20, 32'd0, "rd 0x20 after abort", r);
        check("abort ram kept", r, 32'h11);

        // Random traffic against the model
        for (int n = 0; n < 60; n++) begin
            sw = 16'($urandom);
            if ($urandom_range(0, 9) < 6) begin
                a = $urandom;
                a[11:2] = 10'($urandom_range(0, 15));
                if (is_io(a)) a[31] = 1'b0;
            end else begin
                case ($urandom_range(0, 5))
                    0:       a = IOB;
                    1:       a = IOB + 32'h04;
                    2:       a = IOB + 32'h08;
                    3:       a = IOB + 32'h40;
                    4:       a = IOB + 32'hFC;
                    default: a = IOB + 32'h14;
                endcase
                a[1:0] = 2'($urandom);
            end
            xfer(1'($urandom), a, $urandom, $sformatf("rnd%0d", n), r);
            check($sformatf("rnd%0d led", n), {16'd0, led}, {16'd0, led_m});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
